// File: rtl/tb_sim_ctrl.sv
// Simulation controller for a test harness.
//
// Holds the harness in reset for RST_CYCLES cycles after rst_i deasserts, then
// runs it until it reports an exit code or the RUN-state watchdog expires.
// DONE and TOUT are terminal until the next rst_i.
//
// Parameters:
//   RST_CYCLES     - cycles dut_rst_no stays low after rst_i falls (1..255)
//   TIMEOUT_CYCLES - RUN-state watchdog limit in cycles; 0 disables it
//   EXIT_W         - exit code width
//
// Ports:
//   clk_i        - clock, all state on the rising edge
//   rst_i        - asynchronous active-high reset
//   dut_rst_no   - registered active-low reset to the harness, high only in RUN
//   eoc_valid_i  - exit code valid
//   eoc_code_i   - exit code, 0 means pass
//   eoc_ready_o  - ready for an exit code (RUN only)
//   done_o       - exit code received (sticky)
//   pass_o       - done with exit code 0
//   timeout_o    - watchdog expired (sticky)
//   exit_code_o  - captured exit code
//   cycle_cnt_o  - cycles spent in RUN, saturating
module tb_sim_ctrl #(
    parameter int unsigned RST_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned EXIT_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              dut_rst_no,
    input  logic              eoc_valid_i,
    input  logic [EXIT_W-1:0] eoc_code_i,
    output logic              eoc_ready_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [EXIT_W-1:0] exit_code_o,
    output logic [31:0]       cycle_cnt_o
);

    typedef enum logic [1:0] {
        StHold,
        StRun,
        StDone,
        StTout
    } state_e;

    localparam logic [7:0]  HoldLast = 8'(RST_CYCLES - 1);
    localparam bit          WdogEn   = (TIMEOUT_CYCLES != 0);
    // Only meaningful when WdogEn is set; the wrap for 0 is never used.
    localparam logic [31:0] WdogLast = 32'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [7:0]          hold_cnt_q, hold_cnt_d;
    logic                dut_rst_n_q, dut_rst_n_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                timeout_q, timeout_d;
    logic [EXIT_W-1:0]   exit_code_q, exit_code_d;
    logic [31:0]         cycle_cnt_q, cycle_cnt_d;

    logic in_run;
    logic accept;
    logic wdog_hit;
    logic cnt_sat;

    assign in_run   = (state_q == StRun);
    assign accept   = in_run & eoc_valid_i;
    assign wdog_hit = WdogEn & in_run & (cycle_cnt_q == WdogLast);
    assign cnt_sat  = &cycle_cnt_q;

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        exit_code_d = exit_code_q;
        cycle_cnt_d = cycle_cnt_q;

        unique case (state_q)
            StHold: begin
                if (hold_cnt_q == HoldLast) begin
                    state_d    = StRun;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            StRun: begin
                // An exit code wins over a watchdog expiring on the same cycle.
                // The counter only advances on edges that stay in RUN, so it
                // freezes at the value seen on the final RUN cycle.
                if (accept) begin
                    state_d     = StDone;
                    done_d      = 1'b1;
                    exit_code_d = eoc_code_i;
                    pass_d      = (eoc_code_i == '0);
                end else if (wdog_hit) begin
                    state_d   = StTout;
                    timeout_d = 1'b1;
                end else if (!cnt_sat) begin
                    cycle_cnt_d = cycle_cnt_q + 32'd1;
                end
            end
            StDone, StTout: begin
                state_d = state_q;
            end
            default: begin
                state_d = StHold;
            end
        endcase

        // Registered from the next state so the harness reset rises exactly on
        // the first RUN cycle and never combinationally from rst_i.
        dut_rst_n_d = (state_d == StRun);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StHold;
            hold_cnt_q  <= '0;
            dut_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            exit_code_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            dut_rst_n_q <= dut_rst_n_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            exit_code_q <= exit_code_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign dut_rst_no  = dut_rst_n_q;
    assign eoc_ready_o = in_run;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign timeout_o   = timeout_q;
    assign exit_code_o = exit_code_q;
    assign cycle_cnt_o = cycle_cnt_q;

endmodule

// File: tb/tb_tb_sim_ctrl.sv
// Bench for tb_sim_ctrl: three instances (watchdog 1000, 20 and disabled)
// share clock and reset. A timeline model derived from the edge count since
// reset release predicts every output each cycle; directed phases add literal
// expectations, then randomized exit codes and reset pulses follow.
module tb_tb_sim_ctrl;

    localparam int RST = 4;
    localparam int N   = 3;

    int unsigned to_cyc [N] = '{1000, 20, 0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid [N];
    logic [31:0] code  [N];
    logic        rstn  [N];
    logic        ready [N];
    logic        done  [N];
    logic        pass  [N];
    logic        tout  [N];
    logic [31:0] xcode [N];
    logic [31:0] cnt   [N];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tb_sim_ctrl #(.RST_CYCLES(RST), .TIMEOUT_CYCLES(1000), .EXIT_W(32)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .dut_rst_no(rstn[0]), .eoc_valid_i(valid[0]),
        .eoc_code_i(code[0]), .eoc_ready_o(ready[0]), .done_o(done[0]), .pass_o(pass[0]),
        .timeout_o(tout[0]), .exit_code_o(xcode[0]), .cycle_cnt_o(cnt[0])
    );
    tb_sim_ctrl #(.RST_CYCLES(RST), .TIMEOUT_CYCLES(20), .EXIT_W(32)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .dut_rst_no(rstn[1]), .eoc_valid_i(valid[1]),
        .eoc_code_i(code[1]), .eoc_ready_o(ready[1]), .done_o(done[1]), .pass_o(pass[1]),
        .timeout_o(tout[1]), .exit_code_o(xcode[1]), .cycle_cnt_o(cnt[1])
    );
    tb_sim_ctrl #(.RST_CYCLES(RST), .TIMEOUT_CYCLES(0), .EXIT_W(32)) u_dut_c (
        .clk_i(clk), .rst_i(rst), .dut_rst_no(rstn[2]), .eoc_valid_i(valid[2]),
        .eoc_code_i(code[2]), .eoc_ready_o(ready[2]), .done_o(done[2]), .pass_o(pass[2]),
        .timeout_o(tout[2]), .exit_code_o(xcode[2]), .cycle_cnt_o(cnt[2])
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Model: edges since reset release, plus how the run ended (0 none,
    // 1 exit code, 2 watchdog), the captured code and the frozen count.
    int unsigned m_edges [N];
    int          m_fin   [N];
    logic [31:0] m_code  [N];
    longint      m_frz   [N];

    function automatic bit m_running(input int i);
        return (m_fin[i] == 0) && (m_edges[i] >= RST);
    endfunction

    function automatic longint m_cnt(input int i);
        longint c;
        if (m_fin[i] != 0) return m_frz[i];
        if (m_edges[i] < RST) return 0;
        c = longint'(m_edges[i]) - RST;
        if (c > 64'hFFFF_FFFF) c = 64'hFFFF_FFFF;
        return c;
    endfunction

    always begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_edges[i] = 0;
                m_fin[i]   = 0;
                m_code[i]  = '0;
                m_frz[i]   = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                longint c;
                c = m_cnt(i);
                if (m_running(i)) begin
                    if (valid[i]) begin
                        m_fin[i]  = 1;
                        m_code[i] = code[i];
                        m_frz[i]  = c;
                    end else if (to_cyc[i] > 0 && c == longint'(to_cyc[i]) - 1) begin
                        m_fin[i] = 2;
                        m_frz[i] = c;
                    end
                end
                if (m_fin[i] == 0) m_edges[i]++;
            end
        end
    end

    // Per-cycle comparison against the model, away from the clock edge.
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("dut_rst_no[%0d]", i), rstn[i], m_running(i));
            chk($sformatf("eoc_ready[%0d]", i), ready[i], m_running(i));
            chk($sformatf("done[%0d]", i), done[i], m_fin[i] == 1);
            chk($sformatf("pass[%0d]", i), pass[i], m_fin[i] == 1 && m_code[i] == 0);
            chk($sformatf("timeout[%0d]", i), tout[i], m_fin[i] == 2);
            chk($sformatf("exit_code[%0d]", i), xcode[i], (m_fin[i] == 1) ? m_code[i] : 0);
            chk($sformatf("cycle_cnt[%0d]", i), cnt[i], m_cnt(i));
            chk($sformatf("done_and_tout[%0d]", i), done[i] & tout[i], 0);
            chk($sformatf("pass_wo_done[%0d]", i), pass[i] & ~done[i], 0);
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int len;
        for (int i = 0; i < N; i++) begin
            valid[i] = 1'b0;
            code[i]  = '0;
        end

        // Reset values, then release and HOLD length.
        wait_neg(2);
        chk("rst_dut_rst_no", rstn[0], 0);
        chk("rst_ready", ready[0], 0);
        chk("rst_cnt", cnt[2], 0);
        chk("rst_done", done[1], 0);
        rst = 1'b0;
        for (int e = 1; e <= RST; e++) begin
            wait_neg(1);
            chk("hold_dut_rst_no", rstn[0], e == RST);
            chk("hold_ready", ready[0], e == RST);
        end

        // Pass after 10 RUN cycles on A; B times out; C keeps counting.
        wait_neg(10);
        chk("a_cnt_10", cnt[0], 10);
        valid[0] = 1'b1;
        code[0]  = 32'd0;
        wait_neg(1);
        valid[0] = 1'b0;
        chk("a_done", done[0], 1);
        chk("a_pass", pass[0], 1);
        chk("a_code0", xcode[0], 0);
        chk("a_cnt_frozen", cnt[0], 10);
        chk("a_dut_rst_no", rstn[0], 0);
        wait_neg(8);
        chk("b_tout_early", tout[1], 0);
        chk("b_cnt_19", cnt[1], 19);
        wait_neg(1);
        chk("b_tout", tout[1], 1);
        chk("b_tout_cnt", cnt[1], 19);
        chk("b_tout_done", done[1], 0);
        wait_neg(30);
        chk("c_cnt_50", cnt[2], 50);

        // Asynchronous reset mid-RUN; valid driven in HOLD must be ignored.
        rst = 1'b1;
        #1;
        chk("arst_c_dut_rst_no", rstn[2], 0);
        chk("arst_c_cnt", cnt[2], 0);
        chk("arst_c_ready", ready[2], 0);
        chk("arst_a_done", done[0], 0);
        chk("arst_a_pass", pass[0], 0);
        chk("arst_b_tout", tout[1], 0);
        for (int i = 0; i < N; i++) begin
            valid[i] = 1'b1;
            code[i]  = 32'd3;
        end
        wait_neg(1);
        rst = 1'b0;
        wait_neg(RST);
        for (int i = 0; i < N; i++) begin
            valid[i] = 1'b0;
            chk("hold_ignored_done", done[i], 0);
            chk("rerun_ready", ready[i], 1);
        end

        // Failing code, then a second code in DONE must not disturb anything.
        wait_neg(3);
        valid[0] = 1'b1;
        code[0]  = 32'h5;
        wait_neg(1);
        code[0]  = 32'h7;
        chk("a_fail_pass", pass[0], 0);
        chk("a_fail_code", xcode[0], 5);
        wait_neg(3);
        valid[0] = 1'b0;
        chk("a_stable_code", xcode[0], 5);
        chk("a_stable_cnt", cnt[0], 3);
        chk("a_stable_done", done[0], 1);

        // Exit code on the cycle the watchdog would expire.
        wait_neg(12);
        valid[1] = 1'b1;
        code[1]  = 32'h9;
        wait_neg(1);
        valid[1] = 1'b0;
        chk("b_tie_done", done[1], 1);
        chk("b_tie_tout", tout[1], 0);
        chk("b_tie_cnt", cnt[1], 19);

        // Disabled watchdog keeps counting.
        wait_neg(4980);
        chk("c_cnt_5000", cnt[2], 5000);
        chk("c_no_tout", tout[2], 0);

        // Randomized exit codes and reset pulses, checked by the model.
        for (int r = 0; r < 6; r++) begin
            rst = 1'b1;
            wait_neg(1 + $urandom_range(0, 1));
            rst = 1'b0;
            len = $urandom_range(20, 400);
            for (int k = 0; k < len; k++) begin
                wait_neg(1);
                for (int i = 0; i < N; i++) begin
                    valid[i] = ($urandom_range(0, 39) == 0);
                    code[i]  = ($urandom_range(0, 1) == 1) ? 32'd0 : $urandom;
                end
                if ($urandom_range(0, 199) == 0) begin
                    rst = 1'b1;
                    #2;
                    rst = 1'b0;
                end
            end
        end
        for (int i = 0; i < N; i++) valid[i] = 1'b0;
        wait_neg(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
